// File: rtl/quad_encoder_cmd_if.sv
// Encoder/button inputs and command strobes exchanged between a stimulus
// source (master) and the quadrature command generator (slave).
interface quad_encoder_cmd_if;
   logic enc_a;
   logic enc_b;
   logic btn_load;
   logic up;
   logic down;
   logic load;
   logic err;

   modport master (output enc_a, enc_b, btn_load, input up, down, load, err);
   modport slave  (input enc_a, enc_b, btn_load, output up, down, load, err);
endinterface

// File: rtl/quad_encoder_cmd.sv
// Quadrature encoder + load button front end: synchronise, debounce, decode
// Gray-code steps into one-cycle up/down/load/err strobes for counter_4bit.
module quad_encoder_cmd #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   quad_encoder_cmd_if.slave  bus
);
   localparam int NIN = 3;
   localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int WW  = $clog2(DEBOUNCE_CYCLES + 2);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WW-1:0] WARM_LAST = WW'(DEBOUNCE_CYCLES + 1);

   typedef enum logic {WARMUP, TRACK} state_t;

   // bit 2 = button, bit 1 = A, bit 0 = B
   logic [NIN-1:0]          raw;
   logic [NIN-1:0]          sync1_q, sync2_q, filt_q, prev_q;
   logic [NIN-1:0][CW-1:0]  cnt_q;
   state_t                  state_q;
   logic [WW-1:0]           warm_q;
   logic                    up_q, down_q, load_q, err_q;
   logic                    fwd_d, rev_d, bad_d, ld_d;

   assign raw = {bus.btn_load, bus.enc_a, bus.enc_b};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // Filtered value follows the synced input only after a full run of
   // mismatching cycles; during warm-up it tracks directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         filt_q <= '0;
      end else begin
         for (int i = 0; i < NIN; i++) begin
            if (state_q == WARMUP) begin
               filt_q[i] <= sync2_q[i];
               cnt_q[i]  <= '0;
            end else if (sync2_q[i] != filt_q[i]) begin
               if (cnt_q[i] == CNT_LAST) begin
                  filt_q[i] <= sync2_q[i];
                  cnt_q[i]  <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + CW'(1);
               end
            end else begin
               cnt_q[i] <= '0;
            end
         end
      end
   end

   always_comb begin
      fwd_d = 1'b0;
      rev_d = 1'b0;
      case ({prev_q[1:0], filt_q[1:0]})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd_d = 1'b1;
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: rev_d = 1'b1;
         default: ;
      endcase
      bad_d = (filt_q[1:0] == ~prev_q[1:0]);
      ld_d  = filt_q[2] & ~prev_q[2];
   end

   // prev_q is the last decoded position; a load in the same cycle swallows the step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WARMUP;
         warm_q  <= '0;
         prev_q  <= '0;
         up_q    <= 1'b0;
         down_q  <= 1'b0;
         load_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            WARMUP: begin
               prev_q <= sync2_q;
               up_q   <= 1'b0;
               down_q <= 1'b0;
               load_q <= 1'b0;
               err_q  <= 1'b0;
               if (warm_q == WARM_LAST) state_q <= TRACK;
               else                     warm_q  <= warm_q + WW'(1);
            end
            TRACK: begin
               prev_q <= filt_q;
               up_q   <= fwd_d & ~ld_d;
               down_q <= rev_d & ~ld_d;
               load_q <= ld_d;
               err_q  <= bad_d;
            end
            default: state_q <= WARMUP;
         endcase
      end
   end

   assign bus.up   = up_q;
   assign bus.down = down_q;
   assign bus.load = load_q;
   assign bus.err  = err_q;
endmodule

// File: tb/tb_quad_encoder_cmd.sv
// Randomised bench for quad_encoder_cmd: a window-based reference model
// predicts strobe events into a queue that a negedge monitor drains.
module tb_quad_encoder_cmd;
   localparam int D = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   quad_encoder_cmd_if bus();

   quad_encoder_cmd #(.DEBOUNCE_CYCLES(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         t;
      logic [3:0] v;   // {up, down, load, err}
   } ev_t;

   ev_t        exp_q[$];
   int         checks = 0;
   int         failures = 0;
   int         t = 0;          // clock edges since reset release
   logic [2:0] rh [0:16383];   // raw {btn,A,B} sampled at each edge
   int         p = 0;          // intended encoder position

   function automatic logic [2:0] rget(input int i);
      if (i <= 0 || i > 16383) return 3'b000;
      return rh[i];
   endfunction

   function automatic int gpos(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] gcode(input int pos);
      case (pos & 3)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   // Reference: a filtered bit flips when the last D synced samples (raw delayed
   // two edges) all disagree with it; each filtered change produces one event
   // on the following edge, classified by position difference modulo 4.
   initial begin
      logic [2:0] fcur, fnew, s;
      logic       ld;
      bit         flip;
      int         diff;
      logic [3:0] v;
      fcur = 3'b000;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            t = 0;
            fcur = 3'b000;
         end else begin
            t++;
            if (t <= 16383) rh[t] = {bus.btn_load, bus.enc_a, bus.enc_b};
            if (t <= D + 2) begin
               fcur = rget(t - 2);
            end else begin
               fnew = fcur;
               for (int k = 0; k < 3; k++) begin
                  flip = 1'b1;
                  for (int j = 2; j <= D + 1; j++) begin
                     s = rget(t - j);
                     if (s[k] == fcur[k]) flip = 1'b0;
                  end
                  if (flip) fnew[k] = ~fcur[k];
               end
               if (fnew != fcur) begin
                  ld   = fnew[2] & ~fcur[2];
                  diff = (gpos(fnew[1:0]) - gpos(fcur[1:0]) + 4) % 4;
                  v    = {(diff == 1) && !ld, (diff == 3) && !ld, ld, diff == 2};
                  if (v != 4'b0000) exp_q.push_back('{t + 1, v});
               end
               fcur = fnew;
            end
         end
      end
   end

   initial begin
      logic [3:0] v;
      ev_t        e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].t < t) begin
               e = exp_q.pop_front();
               checks++;
               failures++;
               $display("FAIL missed_strobe: edge %0d got nothing, required {up,down,load,err}=%b",
                        e.t, e.v);
            end
            v = {bus.up, bus.down, bus.load, bus.err};
            if (v != 4'b0000) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_strobe: edge %0d got %b, required 0000", t, v);
               end else begin
                  e = exp_q.pop_front();
                  if (e.t != t || e.v != v) begin
                     failures++;
                     $display("FAIL strobe: edge %0d got %b, required %b at edge %0d",
                              t, v, e.v, e.t);
                  end
               end
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ab(input logic [1:0] ab);
      bus.enc_a = ab[1];
      bus.enc_b = ab[0];
   endtask

   task automatic chk_zero(input string nm);
      checks++;
      if ({bus.up, bus.down, bus.load, bus.err} !== 4'b0000) begin
         failures++;
         $display("FAIL %s: outputs=%b required 0000", nm,
                  {bus.up, bus.down, bus.load, bus.err});
      end
   endtask

   task automatic walk(input int steps);
      int r;
      for (int i = 0; i < steps; i++) begin
         r = $urandom_range(0, 9);
         if (r < 4)      p = p + 1;
         else if (r < 8) p = p + 3;
         else if (r < 9) p = p + 2;
         set_ab(gcode(p));
         cyc($urandom_range(D, 16));
      end
   endtask

   initial begin
      logic [2:0] m;
      logic [2:0] cur;
      bit         seen;
      bus.enc_a = 1'b1;
      bus.enc_b = 1'b1;
      bus.btn_load = 1'b0;
      rst_n = 1'b0;
      cyc(3);
      chk_zero("reset_state");
      rst_n = 1'b1;
      cyc(D + 2);
      chk_zero("warmup_quiet");
      cyc(20);
      chk_zero("warmup_reference");

      p = 0;
      set_ab(2'b00);
      cyc(20);
      for (int i = 0; i < 4; i++) begin p = p + 1; set_ab(gcode(p)); cyc(20); end
      for (int i = 0; i < 4; i++) begin p = p + 3; set_ab(gcode(p)); cyc(20); end
      p = p + 2; set_ab(gcode(p)); cyc(20);
      p = p + 1; set_ab(gcode(p)); cyc(20);

      walk(60);

      for (int i = 0; i < 12; i++) begin
         m = 3'b001 << $urandom_range(0, 2);
         {bus.btn_load, bus.enc_a, bus.enc_b} = {bus.btn_load, bus.enc_a, bus.enc_b} ^ m;
         cyc($urandom_range(1, D - 1));
         {bus.btn_load, bus.enc_a, bus.enc_b} = {bus.btn_load, bus.enc_a, bus.enc_b} ^ m;
         cyc(10);
      end

      for (int i = 0; i < 3; i++) begin
         bus.btn_load = 1'b1; cyc(20);
         bus.btn_load = 1'b0; cyc(20);
      end

      for (int i = 0; i < 4; i++) begin
         bus.btn_load = 1'b1;
         p = p + ((i % 2 == 0) ? 1 : 3);
         set_ab(gcode(p));
         cyc(20);
         bus.btn_load = 1'b0;
         cyc(20);
      end

      repeat (800) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            m = 3'($urandom_range(1, 7));
            {bus.btn_load, bus.enc_a, bus.enc_b} = {bus.btn_load, bus.enc_a, bus.enc_b} ^ m;
         end
      end
      bus.btn_load = 1'b0;
      cur = {1'b0, bus.enc_a, bus.enc_b};
      p = gpos(cur[1:0]);
      cyc(20);

      p = p + 1; set_ab(gcode(p));
      cyc(3);
      @(posedge clk); #3;
      rst_n = 1'b0;
      exp_q.delete();
      #1 chk_zero("async_reset_mid_debounce");
      cyc(3);
      rst_n = 1'b1;
      cyc(D + 12);
      chk_zero("rewarm_quiet");

      p = p + 1; set_ab(gcode(p));
      seen = 1'b0;
      for (int n = 0; n < 30 && !seen; n++) begin
         @(posedge clk); #1;
         if (bus.up | bus.down) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL strobe_timeout: no up/down within 30 cycles, required one");
      end
      #2 rst_n = 1'b0;
      exp_q.delete();
      #1 chk_zero("async_reset_clears_strobe");
      cyc(2);
      rst_n = 1'b1;
      cyc(30);

      walk(12);
      cyc(30);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_events: %0d left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
